// File: rtl/seq_control_pkg.sv
// Shared types and helpers for the step sequencer and the datapath decoders that consume its
// one-hot step vector.
package seq_control_pkg;

    localparam int MAX_STEPS = 32;

    typedef enum logic [2:0] {
        ACT_STAY,
        ACT_ADV,
        ACT_HOLD,
        ACT_SRESET,
        ACT_RECOVER
    } act_e;

    function automatic int idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic bit params_ok(input int n, input int dw, input int bs,
                                     input int bt, input int lp);
        return (n >= 3) && (n <= MAX_STEPS) && (dw >= 1) &&
               (bs >= 1) && (bs <= n - 2) &&
               (bt >= bs + 1) && (bt <= n - 1) &&
               (lp >= 1) && (lp <= n - 1);
    endfunction

    // OR-reduction of indices: exact for a one-hot input, which is all callers ever pass.
    function automatic logic [4:0] oh2bin(input logic [31:0] oh);
        logic [4:0] b;
        b = '0;
        for (int i = 0; i < MAX_STEPS; i++) begin
            if (oh[i]) b = b | 5'(i);
        end
        return b;
    endfunction

    function automatic logic [31:0] bin2oh(input logic [4:0] b);
        return 32'h1 << b;
    endfunction

    function automatic bit is_onehot(input logic [31:0] v);
        return (v != '0) && ((v & (v - 32'd1)) == '0);
    endfunction

endpackage

// File: rtl/seq_control_if.sv
// Control inputs and step outputs of the sequencer; master drives requests, slave is the sequencer.
interface seq_control_if #(
    parameter int N_STEPS = 6,
    parameter int DWELL_W = 4
) ();
    localparam int IW = seq_control_pkg::idx_w(N_STEPS);

    logic               SRESET;
    logic               OVERFLOW;
    logic               CLR;
    logic               STOP;
    logic               HOLD;
    logic [DWELL_W-1:0] DWELL;
    logic [N_STEPS-1:0] S;
    logic [IW-1:0]      STEP_IDX;
    logic               BUSY;
    logic               WRAP;
    logic [7:0]         LOOP_CNT;

    modport master (
        output SRESET, OVERFLOW, CLR, STOP, HOLD, DWELL,
        input  S, STEP_IDX, BUSY, WRAP, LOOP_CNT
    );

    modport slave (
        input  SRESET, OVERFLOW, CLR, STOP, HOLD, DWELL,
        output S, STEP_IDX, BUSY, WRAP, LOOP_CNT
    );
endinterface

// File: rtl/seq_dwell_cnt.sv
// Loadable dwell down-counter with clear and hold; zero_o flags that the current step may advance.
// Counter stops at zero rather than wrapping.
module seq_dwell_cnt #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr_i,
    input  logic         hold_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         zero_o
);
    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (!hold_i) begin
            if (load_i)            cnt_d = load_val_i;
            else if (cnt_q != '0)  cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign zero_o = (cnt_q == '0);
endmodule

// File: rtl/seq_control_p.sv
// Parametrised one-hot step sequencer with per-step dwell, hold, branch, loop-back and loop counter.
// All outputs registered; step 0 leaves one cycle after OVERFLOW.
module seq_control_p
    import seq_control_pkg::*;
#(
    parameter int N_STEPS       = 6,
    parameter int DWELL_W       = 4,
    parameter int BRANCH_STEP   = 2,
    parameter int BRANCH_TARGET = 5,
    parameter int LOOP_STEP     = 1
) (
    input  logic          CLK,
    input  logic          RESET_N,
    seq_control_if.slave  bus
);
    localparam int IW = idx_w(N_STEPS);

    if (!params_ok(N_STEPS, DWELL_W, BRANCH_STEP, BRANCH_TARGET, LOOP_STEP)) begin : g_bad_params
        $error("seq_control_p: illegal parameter combination");
    end

    logic [N_STEPS-1:0] s_q, s_d;
    logic [IW-1:0]      idx_q, idx_d;
    logic               busy_q, busy_d;
    logic               wrap_q, wrap_d;
    logic [7:0]         loop_q, loop_d;
    logic [31:0]        s_ext;
    logic [4:0]         cur_idx, nxt_idx;
    logic               legal, cnt_zero, cnt_clr, cnt_hold, cnt_load;
    act_e               act;

    seq_dwell_cnt #(.W(DWELL_W)) u_dwell (
        .clk        (CLK),
        .rst_n      (RESET_N),
        .clr_i      (cnt_clr),
        .hold_i     (cnt_hold),
        .load_i     (cnt_load),
        .load_val_i (bus.DWELL),
        .zero_o     (cnt_zero)
    );

    always_comb begin
        s_ext              = '0;
        s_ext[N_STEPS-1:0] = s_q;
        cur_idx            = oh2bin(s_ext);
        legal              = is_onehot(s_ext);

        // Branch and wrap targets; CLR and STOP only matter on these two advances.
        if (s_q[0])                               nxt_idx = 5'd1;
        else if (cur_idx == 5'(BRANCH_STEP))      nxt_idx = bus.CLR ? 5'(BRANCH_TARGET) : 5'(BRANCH_STEP + 1);
        else if (cur_idx == 5'(N_STEPS - 1))      nxt_idx = bus.STOP ? 5'd0 : 5'(LOOP_STEP);
        else                                      nxt_idx = cur_idx + 5'd1;

        if (bus.SRESET)                                   act = ACT_SRESET;
        else if (!legal)                                  act = ACT_RECOVER;
        else if (bus.HOLD)                                act = ACT_HOLD;
        else if (s_q[0] ? bus.OVERFLOW : cnt_zero)        act = ACT_ADV;
        else                                              act = ACT_STAY;

        s_d      = s_q;
        idx_d    = idx_q;
        busy_d   = busy_q;
        wrap_d   = 1'b0;
        loop_d   = loop_q;
        cnt_clr  = 1'b0;
        cnt_hold = 1'b0;
        cnt_load = 1'b0;

        case (act)
            ACT_SRESET, ACT_RECOVER: begin
                s_d     = '0;
                s_d[0]  = 1'b1;
                idx_d   = '0;
                busy_d  = 1'b0;
                cnt_clr = 1'b1;
                if (act == ACT_SRESET) loop_d = '0;
            end
            ACT_HOLD: cnt_hold = 1'b1;
            ACT_ADV: begin
                for (int k = 0; k < N_STEPS; k++) s_d[k] = (5'(k) == nxt_idx);
                idx_d    = nxt_idx[IW-1:0];
                busy_d   = (nxt_idx != 5'd0);
                cnt_load = (nxt_idx != 5'd0);
                if (s_q[N_STEPS-1]) begin
                    wrap_d = 1'b1;
                    if (loop_q != 8'hFF) loop_d = loop_q + 8'd1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            s_q    <= N_STEPS'(1);
            idx_q  <= '0;
            busy_q <= 1'b0;
            wrap_q <= 1'b0;
            loop_q <= '0;
        end else begin
            s_q    <= s_d;
            idx_q  <= idx_d;
            busy_q <= busy_d;
            wrap_q <= wrap_d;
            loop_q <= loop_d;
        end
    end

    assign bus.S        = s_q;
    assign bus.STEP_IDX = idx_q;
    assign bus.BUSY     = busy_q;
    assign bus.WRAP     = wrap_q;
    assign bus.LOOP_CNT = loop_q;
endmodule

// File: tb/tb_seq_control_p.sv
// Drives a default-parameter and an 8-step sequencer with identical stimulus and checks both
// against a cycle model through per-instance expectation queues.
module tb_seq_control_p;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sreset = 1'b0, ov = 1'b0, clr = 1'b0, stop = 1'b0, hold = 1'b0;
    logic [3:0] dwell = 4'd0;

    int checks = 0;
    int failures = 0;
    int s3_cyc = 0;

    always #5 clk = ~clk;

    seq_control_if #(.N_STEPS(6), .DWELL_W(4)) if_a ();
    seq_control_if #(.N_STEPS(8), .DWELL_W(4)) if_b ();

    assign if_a.SRESET = sreset;  assign if_b.SRESET = sreset;
    assign if_a.OVERFLOW = ov;    assign if_b.OVERFLOW = ov;
    assign if_a.CLR = clr;        assign if_b.CLR = clr;
    assign if_a.STOP = stop;      assign if_b.STOP = stop;
    assign if_a.HOLD = hold;      assign if_b.HOLD = hold;
    assign if_a.DWELL = dwell;    assign if_b.DWELL = dwell;

    seq_control_p #(.N_STEPS(6), .DWELL_W(4), .BRANCH_STEP(2), .BRANCH_TARGET(5), .LOOP_STEP(1))
        dut_a (.CLK(clk), .RESET_N(rst_n), .bus(if_a.slave));
    seq_control_p #(.N_STEPS(8), .DWELL_W(4), .BRANCH_STEP(3), .BRANCH_TARGET(6), .LOOP_STEP(2))
        dut_b (.CLK(clk), .RESET_N(rst_n), .bus(if_b.slave));

    typedef struct {
        int step;
        int loop;
        bit wrap;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];

    int m_step[2], m_cnt[2], m_loop[2];
    bit m_wrap[2];
    int pn[2]  = '{6, 8};
    int pbs[2] = '{2, 3};
    int pbt[2] = '{5, 6};
    int plp[2] = '{1, 2};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_step[d] = 0; m_cnt[d] = 0; m_loop[d] = 0; m_wrap[d] = 1'b0;
        end
    endtask

    task automatic model(input int d);
        int nx;
        m_wrap[d] = 1'b0;
        if (sreset) begin
            m_step[d] = 0; m_cnt[d] = 0; m_loop[d] = 0;
        end else if (!hold) begin
            if (m_step[d] == 0) begin
                if (ov) begin m_step[d] = 1; m_cnt[d] = int'(dwell); end
            end else if (m_cnt[d] != 0) begin
                m_cnt[d] = m_cnt[d] - 1;
            end else begin
                if (m_step[d] == pbs[d]) nx = clr ? pbt[d] : pbs[d] + 1;
                else if (m_step[d] == pn[d] - 1) begin
                    nx = stop ? 0 : plp[d];
                    m_wrap[d] = 1'b1;
                    if (m_loop[d] < 255) m_loop[d] = m_loop[d] + 1;
                end else nx = m_step[d] + 1;
                m_step[d] = nx;
                m_cnt[d]  = (nx != 0) ? int'(dwell) : 0;
            end
        end
    endtask

    task automatic tick();
        exp_t e;
        model(0);
        e.step = m_step[0]; e.loop = m_loop[0]; e.wrap = m_wrap[0];
        q_a.push_back(e);
        model(1);
        e.step = m_step[1]; e.loop = m_loop[1]; e.wrap = m_wrap[1];
        q_b.push_back(e);
        @(posedge clk);
        #1;
        e = q_a.pop_front();
        chk("a_S",    32'(if_a.S),        32'h1 << e.step);
        chk("a_IDX",  32'(if_a.STEP_IDX), e.step);
        chk("a_BUSY", 32'(if_a.BUSY),     32'(e.step != 0));
        chk("a_WRAP", 32'(if_a.WRAP),     32'(e.wrap));
        chk("a_LOOP", 32'(if_a.LOOP_CNT), e.loop);
        e = q_b.pop_front();
        chk("b_S",    32'(if_b.S),        32'h1 << e.step);
        chk("b_IDX",  32'(if_b.STEP_IDX), e.step);
        chk("b_BUSY", 32'(if_b.BUSY),     32'(e.step != 0));
        chk("b_WRAP", 32'(if_b.WRAP),     32'(e.wrap));
        chk("b_LOOP", 32'(if_b.LOOP_CNT), e.loop);
        if (if_a.S[3]) s3_cyc++;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_a_S"},    32'(if_a.S),        32'h1);
        chk({tag, "_a_IDX"},  32'(if_a.STEP_IDX), 32'h0);
        chk({tag, "_a_BUSY"}, 32'(if_a.BUSY),     32'h0);
        chk({tag, "_a_WRAP"}, 32'(if_a.WRAP),     32'h0);
        chk({tag, "_a_LOOP"}, 32'(if_a.LOOP_CNT), 32'h0);
        chk({tag, "_b_S"},    32'(if_b.S),        32'h1);
        chk({tag, "_b_BUSY"}, 32'(if_b.BUSY),     32'h0);
        chk({tag, "_b_LOOP"}, 32'(if_b.LOOP_CNT), 32'h0);
    endtask

    initial begin
        model_reset();
        #12;
        chk_reset_vals("reset");
        rst_n = 1'b1;

        // Basic walk with a single OVERFLOW pulse, no dwell.
        ticks(2);
        ov = 1'b1; tick(); ov = 1'b0;
        ticks(14);

        // Branch taken on every pass through the branch step.
        clr = 1'b1; ticks(12); clr = 1'b0;

        // Dwell of 3, then shortened mid-step.
        dwell = 4'd3; ticks(10);
        dwell = 4'd1; ticks(10);

        // Hold for 5 cycles in the middle of step 3's dwell.
        sreset = 1'b1; tick(); sreset = 1'b0;
        s3_cyc = 0;
        dwell = 4'd3;
        ov = 1'b1; tick(); ov = 1'b0;
        ticks(9);
        hold = 1'b1; ticks(5); hold = 1'b0;
        ticks(4);
        chk("step3_len", 32'(s3_cyc), 32'd9);

        // Synchronous restart wins over hold.
        hold = 1'b1; ticks(2);
        sreset = 1'b1; tick(); sreset = 1'b0; hold = 1'b0;
        chk("sreset_a_S", 32'(if_a.S), 32'h1);
        chk("sreset_a_LOOP", 32'(if_a.LOOP_CNT), 32'h0);
        ticks(2);

        // Controlled exit, then idle waits for OVERFLOW.
        dwell = 4'd0; stop = 1'b1;
        ov = 1'b1; tick(); ov = 1'b0;
        ticks(12);
        stop = 1'b0;
        ticks(3);
        chk("stop_idle_a", 32'(if_a.S), 32'h1);
        chk("stop_idle_b", 32'(if_b.S), 32'h1);

        // Long run with OVERFLOW held high to saturate LOOP_CNT.
        ov = 1'b1; clr = 1'b1;
        ticks(1300);
        chk("sat_a", 32'(if_a.LOOP_CNT), 32'd255);
        chk("sat_b", 32'(if_b.LOOP_CNT), 32'd255);

        // Asynchronous reset mid-step, observed before any further clock edge.
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_vals("areset");
        model_reset();
        ov = 1'b0; clr = 1'b0;
        #4;
        rst_n = 1'b1;
        ov = 1'b1; tick(); ov = 1'b0;
        ticks(6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seq_control_p.md
Name: seq_control_p

Overview:
Parametrised successor to the fixed six-state one-hot sequencer controller. It generates a one-hot step vector that sequences the datapath. Step count, the conditional branch point and the loop-back point are set by parameters. Adds a programmable per-step dwell, a hold/freeze input, a controlled exit from the loop, a loop counter and a wrap pulse. Sits between the overflow/timer source and the datapath load/enable logic.

Parameters:
N_STEPS, 6, number of steps including idle step 0; legal range 3..32.
DWELL_W, 4, width of DWELL input and of the internal dwell counter.
BRANCH_STEP, 2, step where CLR selects the branch; range 1..N_STEPS-2.
BRANCH_TARGET, 5, step entered from BRANCH_STEP when CLR=1; range BRANCH_STEP+1..N_STEPS-1.
LOOP_STEP, 1, step entered after the last step when STOP=0; range 1..N_STEPS-1.
Any out-of-range parameter is an elaboration error.

Ports:
CLK  in  1  rising-edge clock
RESET_N  in  1  asynchronous, active-low reset
SRESET  in  1  synchronous restart to step 0; active-high
OVERFLOW  in  1  start request; sampled only in step 0
CLR  in  1  branch select; sampled only on the advance out of BRANCH_STEP
STOP  in  1  exit request; sampled only on the advance out of step N_STEPS-1
HOLD  in  1  freeze state and dwell counter
DWELL  in  DWELL_W  extra cycles per step; each step lasts DWELL+1 cycles
S  out  N_STEPS  registered one-hot step vector; S[k]=1 means step k
STEP_IDX  out  clog2(N_STEPS)  binary index of the current step, registered
BUSY  out  1  registered; 1 whenever the current step is not 0
WRAP  out  1  one-cycle pulse, registered; see Behaviour
LOOP_CNT  out  8  completed loops, saturating

Behaviour:
- Reset (RESET_N=0, asynchronous): S=1 (step 0), STEP_IDX=0, BUSY=0, WRAP=0, LOOP_CNT=0, dwell counter=0. Release is synchronous: the first state change is on the first CLK edge after RESET_N rises.
- Per-edge priority: SRESET > HOLD > advance.
- SRESET=1: next state is step 0; dwell counter, LOOP_CNT and WRAP are cleared. HOLD is ignored.
- HOLD=1 (SRESET=0): S, STEP_IDX, dwell counter and LOOP_CNT are unchanged; WRAP=0.
- Step 0: has no dwell. OVERFLOW=1 moves to step 1 on the next edge; otherwise stays in step 0. Latency from OVERFLOW to S[1] is one cycle.
- Steps 1..N_STEPS-1, entry: the dwell counter loads DWELL. DWELL is sampled at entry only, so a mid-step change affects the next step.
- Steps 1..N_STEPS-1, each cycle: the counter decrements while nonzero. The step advances on the cycle the counter is 0, so a step lasts DWELL+1 non-held cycles.
- Advance targets:
  - from BRANCH_STEP: CLR=1 goes to BRANCH_TARGET; CLR=0 goes to BRANCH_STEP+1.
  - from N_STEPS-1: STOP=1 goes to step 0; STOP=0 goes to LOOP_STEP.
  - from any other step k: goes to k+1.
- Wrap: on the advance out of N_STEPS-1, WRAP=1 for that one cycle (both STOP=0 and STOP=1). LOOP_CNT increments by 1 and saturates at 255.
- Next-state logic is evaluated exactly once per cycle; a step's next state is never assigned twice. S is always exactly one-hot. An illegal encoding recovers to step 0 on the next edge.
- OVERFLOW, CLR and STOP have no effect outside their sampling points.
- RESET_N asserted mid-step: immediate return to reset values, regardless of HOLD.

Decomposition:
- Shared package seq_control_pkg holds:
  - STEP_IDX width function (clog2);
  - the parameter-legality check;
  - one-hot/binary conversion functions, shared with the datapath decoders.
- One natural sub-module: seq_dwell_cnt. It is a loadable down-counter with hold and clear, and provides a zero flag for the advance condition.
- The FSM, branch/loop selection and LOOP_CNT stay in the top level.

Test Plan:
- Defaults, DWELL=0, pulse OVERFLOW, CLR=0, STOP=0 -> S walks 000010, 000100, 001000, 010000, 100000, then back to 000010. WRAP pulses once on the 100000->000010 edge; LOOP_CNT=1.
- Defaults, CLR=1 held high -> the advance out of step 2 goes to step 5, skipping 3 and 4. Loop period is 3 cycles; CLR is ignored in every other step.
- DWELL=3 -> each nonzero step lasts exactly 4 cycles. Changing DWELL to 1 mid-step leaves that step at 4 cycles; the next step lasts 2.
- HOLD asserted for 5 cycles mid-dwell in step 3 -> S, STEP_IDX and remaining dwell frozen. Step 3 total is DWELL+1+5 cycles. SRESET during HOLD -> step 0 on the next edge and LOOP_CNT=0.
- STOP=1 on the last step -> goes to step 0, WRAP=1 for one cycle, BUSY falls. Step 0 then waits for OVERFLOW. Run 300 loops -> LOOP_CNT saturates at 255.
- N_STEPS=8, BRANCH_STEP=3, BRANCH_TARGET=6, LOOP_STEP=2 -> branch and loop-back targets follow the parameters. Also: RESET_N low mid-step -> reset values asynchronously, without waiting for a CLK edge.
